// File: rtl/timer_pkg.sv
// timer_pkg: shared state/mode encodings and parameter limits for the programmable period timer
package timer_pkg;
  typedef enum logic [1:0] {IDLE, RUN, DONE} tmr_state_e;
  typedef enum logic {MODE_PERIODIC, MODE_ONESHOT} tmr_mode_e;
  localparam int CNT_W_MIN = 2;
  localparam int CNT_W_MAX = 64;
  localparam int DIV_W_MIN = 1;
  localparam int DIV_W_MAX = 16;
endpackage

// File: rtl/tmr_prescaler.sv
// tmr_prescaler: counts 0..period while enabled, registered tick on each wrap
module tmr_prescaler #(
  parameter int CNT_W = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             clr,
  input  logic             en,
  input  logic [CNT_W-1:0] period,
  output logic             wrap,
  output logic             tick,
  output logic [CNT_W-1:0] cnt
);
  assign wrap = en && cnt == period;
  always_ff @(posedge clk) begin
    if (rst || clr) begin
      cnt  <= '0;
      tick <= 1'b0;
    end else if (en) begin
      cnt  <= wrap ? '0 : cnt + 1'b1;
      tick <= wrap;
    end else begin
      tick <= 1'b0;
    end
  end
endmodule

// File: rtl/prog_period_timer.sv
// prog_period_timer: programmable prescaler + divider timer with toggle output and one-shot mode
module prog_period_timer
  import timer_pkg::*;
#(
  parameter int               CNT_W      = 32,
  parameter int               DIV_W      = 4,
  parameter logic [CNT_W-1:0] DEF_PERIOD = '1,
  parameter logic [DIV_W-1:0] DEF_DIV    = '1
) (
  input  logic             n0,
  input  logic             n1,
  input  logic             cfg_valid,
  output logic             cfg_ready,
  input  logic [CNT_W-1:0] cfg_period,
  input  logic [DIV_W-1:0] cfg_div,
  input  logic             cfg_oneshot,
  input  logic             start,
  input  logic             stop,
  output logic             tick,
  output logic             out_q,
  output logic             busy,
  output logic             done,
  output logic [CNT_W-1:0] cnt_q
);
  if (CNT_W < CNT_W_MIN || CNT_W > CNT_W_MAX || DIV_W < DIV_W_MIN || DIV_W > DIV_W_MAX) begin : g_bad_width
    $error("prog_period_timer: CNT_W/DIV_W out of range");
  end
  tmr_state_e       state, nxt;
  tmr_mode_e        mode_r;
  logic [CNT_W-1:0] period_r;
  logic [DIV_W-1:0] div_r, sub;
  logic             wrap, en, clr, go, sub_wrap, cfg_acc;
  assign cfg_ready = state != RUN;
  assign busy      = state == RUN;
  assign done      = state == DONE;
  assign cfg_acc   = cfg_valid && cfg_ready;
  assign go        = start && !stop && state != RUN;
  // stop suppresses a same-edge terminal count, so it gates the prescaler enable
  assign en        = state == RUN && !stop;
  assign clr       = go || (state == RUN && stop);
  assign sub_wrap  = wrap && sub == div_r;
  always_comb begin
    nxt = state;
    if (state == RUN)
      nxt = stop ? IDLE : (sub_wrap && mode_r == MODE_ONESHOT) ? DONE : RUN;
    else
      nxt = stop ? IDLE : start ? RUN : state;
  end
  always_ff @(posedge n0) begin
    if (n1) begin
      state    <= IDLE;
      period_r <= DEF_PERIOD;
      div_r    <= DEF_DIV;
      mode_r   <= MODE_PERIODIC;
      sub      <= '0;
      out_q    <= 1'b0;
    end else begin
      state <= nxt;
      if (cfg_acc) begin
        period_r <= cfg_period;
        div_r    <= cfg_div;
        mode_r   <= tmr_mode_e'(cfg_oneshot);
      end
      if (clr) sub <= '0;
      else if (wrap) sub <= sub_wrap ? '0 : sub + 1'b1;
      if (sub_wrap) out_q <= ~out_q;
    end
  end
  tmr_prescaler #(.CNT_W(CNT_W)) u_pre (
    .clk   (n0),
    .rst   (n1),
    .clr   (clr),
    .en    (en),
    .period(period_r),
    .wrap  (wrap),
    .tick  (tick),
    .cnt   (cnt_q)
  );
endmodule

// File: tb/tb_prog_period_timer.sv
// tb_prog_period_timer: directed table-driven checks plus hand sequences for long runs and reset
module tb_prog_period_timer;
  localparam int CW = 8;
  localparam int DW = 2;
  logic          n0 = 0, n1 = 1;
  logic          cfg_valid = 0, cfg_oneshot = 0, start = 0, stop = 0;
  logic [CW-1:0] cfg_period = '0;
  logic [DW-1:0] cfg_div = '0;
  logic          cfg_ready, tick, out_q, busy, done;
  logic [CW-1:0] cnt_q;
  int            checks = 0, errors = 0;
  typedef struct {
    string         nm;
    logic          cv;
    logic [CW-1:0] cp;
    logic [DW-1:0] cd;
    logic          co, st, sp;
    logic          et, eo, eb, ed, er;
    logic [CW-1:0] ec;
  } vec_t;
  vec_t tbl[$];
  prog_period_timer #(.CNT_W(CW), .DIV_W(DW)) dut (
    .n0(n0), .n1(n1), .cfg_valid(cfg_valid), .cfg_ready(cfg_ready),
    .cfg_period(cfg_period), .cfg_div(cfg_div), .cfg_oneshot(cfg_oneshot),
    .start(start), .stop(stop), .tick(tick), .out_q(out_q), .busy(busy),
    .done(done), .cnt_q(cnt_q)
  );
  always #5 n0 = ~n0;
  task automatic step();
    @(posedge n0);
    #1;
  endtask
  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask
  task automatic chk_all(input string nm, input logic et, eo, eb, ed, er, input logic [CW-1:0] ec);
    chk({nm, ".tick"}, 64'(tick), 64'(et));
    chk({nm, ".out_q"}, 64'(out_q), 64'(eo));
    chk({nm, ".busy"}, 64'(busy), 64'(eb));
    chk({nm, ".done"}, 64'(done), 64'(ed));
    chk({nm, ".cfg_ready"}, 64'(cfg_ready), 64'(er));
    chk({nm, ".cnt_q"}, 64'(cnt_q), 64'(ec));
  endtask
  function automatic void add(string nm, logic cv, logic [CW-1:0] cp, logic [DW-1:0] cd,
                              logic co, st, sp, et, eo, eb, ed, er, logic [CW-1:0] ec);
    vec_t v;
    v.nm = nm; v.cv = cv; v.cp = cp; v.cd = cd; v.co = co; v.st = st; v.sp = sp;
    v.et = et; v.eo = eo; v.eb = eb; v.ed = ed; v.er = er; v.ec = ec;
    tbl.push_back(v);
  endfunction
  initial begin
    // periodic P=3 D=1
    add("t2_start", 1, 3, 1, 0, 1, 0, 0, 0, 1, 0, 0, 0);
    for (int k = 1; k <= 16; k++)
      add($sformatf("t2_c%0d", k), 0, 0, 0, 0, 0, 0, k % 4 == 0, k >= 8 && k < 16, 1, 0, 0, CW'(k % 4));
    add("t2_stop", 0, 0, 0, 0, 0, 1, 0, 0, 0, 0, 1, 0);
    // one-shot P=2 D=0, twice, then stop from DONE
    add("t3_start", 1, 2, 0, 1, 1, 0, 0, 0, 1, 0, 0, 0);
    add("t3_c1", 0, 0, 0, 0, 0, 0, 0, 0, 1, 0, 0, 1);
    add("t3_c2", 0, 0, 0, 0, 0, 0, 0, 0, 1, 0, 0, 2);
    add("t3_c3", 0, 0, 0, 0, 0, 0, 1, 1, 0, 1, 1, 0);
    add("t3_hold", 0, 0, 0, 0, 0, 0, 0, 1, 0, 1, 1, 0);
    add("t3_restart", 0, 0, 0, 0, 1, 0, 0, 1, 1, 0, 0, 0);
    add("t3_r1", 0, 0, 0, 0, 0, 0, 0, 1, 1, 0, 0, 1);
    add("t3_r2", 0, 0, 0, 0, 0, 0, 0, 1, 1, 0, 0, 2);
    add("t3_r3", 0, 0, 0, 0, 0, 0, 1, 0, 0, 1, 1, 0);
    add("t3_stop_done", 0, 0, 0, 0, 0, 1, 0, 0, 0, 0, 1, 0);
    // P=5, start in RUN ignored, stop on terminal cycle, start+stop
    add("t5_start", 1, 5, 0, 0, 1, 0, 0, 0, 1, 0, 0, 0);
    add("t5_c1", 0, 0, 0, 0, 0, 0, 0, 0, 1, 0, 0, 1);
    add("t5_c2", 0, 0, 0, 0, 0, 0, 0, 0, 1, 0, 0, 2);
    add("t5_c3_start_ign", 0, 0, 0, 0, 1, 0, 0, 0, 1, 0, 0, 3);
    add("t5_c4", 0, 0, 0, 0, 0, 0, 0, 0, 1, 0, 0, 4);
    add("t5_c5", 0, 0, 0, 0, 0, 0, 0, 0, 1, 0, 0, 5);
    add("t5_stop_term", 0, 0, 0, 0, 0, 1, 0, 0, 0, 0, 1, 0);
    add("t5_start_stop", 0, 0, 0, 0, 1, 1, 0, 0, 0, 0, 1, 0);
    // P=0 D=2, config stalled during RUN then accepted after stop
    add("t4_start", 1, 0, 2, 0, 1, 0, 0, 0, 1, 0, 0, 0);
    for (int k = 1; k <= 9; k++)
      add($sformatf("t4_c%0d", k), k >= 4, 1, 1, 0, 0, 0, 1, (k / 3) % 2 == 1, 1, 0, 0, 0);
    add("t4_stop", 1, 1, 1, 0, 0, 1, 0, 1, 0, 0, 1, 0);
    add("t4_cfg_acc", 1, 1, 1, 0, 0, 0, 0, 1, 0, 0, 1, 0);
    add("t4_new_start", 0, 0, 0, 0, 1, 0, 0, 1, 1, 0, 0, 0);
    add("t4_new_c1", 0, 0, 0, 0, 0, 0, 0, 1, 1, 0, 0, 1);
    add("t4_new_c2", 0, 0, 0, 0, 0, 0, 1, 1, 1, 0, 0, 0);
    // reset
    repeat (2) step();
    chk_all("reset", 0, 0, 0, 0, 1, 0);
    n1 = 0;
    // defaults P=255 D=3
    start = 1; step(); start = 0;
    chk_all("t1_start", 0, 0, 1, 0, 0, 0);
    repeat (255) step();
    chk_all("t1_pre_tick", 0, 0, 1, 0, 0, 255);
    step();
    chk_all("t1_tick1", 1, 0, 1, 0, 0, 0);
    repeat (767) step();
    chk_all("t1_pre_tog", 0, 0, 1, 0, 0, 255);
    step();
    chk_all("t1_tog", 1, 1, 1, 0, 0, 0);
    stop = 1; step(); stop = 0;
    chk_all("t1_stop", 0, 1, 0, 0, 1, 0);
    n1 = 1; step(); n1 = 0;
    chk_all("t1_reset", 0, 0, 0, 0, 1, 0);
    foreach (tbl[i]) begin
      cfg_valid = tbl[i].cv; cfg_period = tbl[i].cp; cfg_div = tbl[i].cd;
      cfg_oneshot = tbl[i].co; start = tbl[i].st; stop = tbl[i].sp;
      step();
      chk_all(tbl[i].nm, tbl[i].et, tbl[i].eo, tbl[i].eb, tbl[i].ed, tbl[i].er, tbl[i].ec);
    end
    cfg_valid = 0; start = 0; stop = 0;
    // reset mid-RUN at cnt 7 with out_q=1
    stop = 1; step(); stop = 0;
    cfg_valid = 1; cfg_period = 20; cfg_div = 0; cfg_oneshot = 0; step(); cfg_valid = 0;
    start = 1; step(); start = 0;
    repeat (7) step();
    chk_all("t6_pre", 0, 1, 1, 0, 0, 7);
    n1 = 1; step(); n1 = 0;
    chk_all("t6_reset", 0, 0, 0, 0, 1, 0);
    start = 1; step(); start = 0;
    repeat (255) step();
    chk_all("t6_defper_pre", 0, 0, 1, 0, 0, 255);
    step();
    chk_all("t6_defper_tick", 1, 0, 1, 0, 0, 0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
